// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder.
//   slave  : the encoder side (takes requests, presents encoded words)
//   master : the producer/consumer side (drives requests and out_ready)
// Signals: in_valid/in_ready + mnem/rd/rs1/rs2/imm request handshake,
//          out_valid/out_ready + out_instr response handshake,
//          err reject pulse, instr_count legal-accept counter.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  mnem;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] instr_count;

  modport slave (
    input  in_valid, mnem, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_instr, err, instr_count
  );

  modport master (
    output in_valid, mnem, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_instr, err, instr_count
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high; clears FIFO, counter and err
//   bus   - instr_encoder_if.slave: request handshake, encoded-word
//           handshake, err pulse, instr_count
// Legal requests are encoded and pushed; illegal ones are dropped and
// raise err for the cycle after acceptance.
module instr_encoder (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus
);
  typedef enum logic [3:0] {
    M_ADD = 4'd0, M_SUB = 4'd1, M_AND = 4'd2, M_OR  = 4'd3, M_SLT = 4'd4,
    M_ADDI = 4'd5, M_LB = 4'd6, M_SB = 4'd7, M_BEQ = 4'd8
  } mnem_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [1:0][31:0] mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        imm_fits12;
  logic        accept, push, pop;

  // A 13-bit value fits 12-bit signed exactly when its top two bits agree.
  assign imm_fits12 = (bus.imm[12] == bus.imm[11]);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (mnem_e'(bus.mnem))
      M_ADD:  enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, OP_R};
      M_SUB:  enc_word = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, OP_R};
      M_AND:  enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b111, bus.rd, OP_R};
      M_OR:   enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b110, bus.rd, OP_R};
      M_SLT:  enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b010, bus.rd, OP_R};
      M_ADDI: begin
        enc_word  = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OP_IMM};
        enc_legal = imm_fits12;
      end
      M_LB: begin
        enc_word  = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OP_LOAD};
        enc_legal = imm_fits12;
      end
      M_SB: begin
        enc_word  = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b000, bus.imm[4:0], OP_ST};
        enc_legal = imm_fits12;
      end
      M_BEQ: begin
        enc_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                     bus.imm[4:1], bus.imm[11], OP_BR};
        enc_legal = ~bus.imm[0];
      end
      default: enc_legal = 1'b0;
    endcase
  end

  assign bus.in_ready    = (occ_q != 2'd2);
  assign bus.out_valid   = (occ_q != 2'd0);
  assign bus.out_instr   = mem_q[rd_ptr_q];
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & enc_legal;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    err_d    = accept & ~enc_legal;
    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      cnt_d           = cnt_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
